// File: rtl/gesture_sequencer_if.sv
// Gesture request / servo position bundle between the gesture input stage and
// the motion sequencer.
interface gesture_if #(
    parameter int PW_W = 16
);
    logic [7:0]        gesture;
    logic              gesture_valid;
    logic [5*PW_W-1:0] pos;
    logic              busy;
    logic              pending;
    logic              done;

    modport master (
        output gesture, gesture_valid,
        input  pos, busy, pending, done
    );

    modport slave (
        input  gesture, gesture_valid,
        output pos, busy, pending, done
    );
endinterface

// File: rtl/gesture_sequencer.sv
// Five-channel servo motion sequencer: gesture code -> slewed pulse-width targets,
// settle hold, one-deep pending buffer. SEQ_STAGGER_EN enables a per-channel start offset.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a gesture request
// S_LOAD   | one cycle: derive targets and step from the active gesture
// S_MOVE   | slew all enabled channels toward target on each tick
// S_SETTLE | hold HOLD_TICKS ticks, then done pulse and next gesture
module gesture_sequencer #(
    parameter int PW_W          = 16,
    parameter int OPEN_US       = 1000,
    parameter int CLOSE_US      = 2000,
    parameter int TICK_DIV      = 50000,
    parameter int STEP_US       = 10,
    parameter int HOLD_TICKS    = 20,
    parameter int STAGGER_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    gesture_if.slave bus
);

`ifdef SEQ_STAGGER_EN
    localparam int STAGGER_EFF = STAGGER_TICKS;
`else
    localparam int STAGGER_EFF = 0 * STAGGER_TICKS;
`endif

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MOVE, S_SETTLE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_tick_cnt;
    logic [HW-1:0]     r_hold_cnt;
    logic [31:0]       r_move_ticks;
    logic [7:0]        r_active;
    logic [7:0]        r_pend_g;
    logic              r_pending;
    logic [PW_W-1:0]   r_pos    [5];
    logic [PW_W-1:0]   r_target [5];
    logic [PW_W-1:0]   r_step;
    logic [PW_W-1:0]   w_pos_nxt [5];
    logic [PW_W-1:0]   w_speed;
    logic [PW_W-1:0]   w_step;
    logic              w_tick;
    logic              w_all_at;
    logic              w_hold_end;
    logic              w_busy;
    logic              w_done;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_hold_end = (r_state == S_SETTLE) && (r_hold_cnt == HOLD_LAST);
    assign w_speed    = PW_W'(r_active[7:5]) + PW_W'(1);
    assign w_step     = PW_W'(STEP_US) * w_speed;

    // Clamp to target whenever the remaining distance is within one step.
    always_comb begin
        w_all_at = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w_pos_nxt[k] = r_pos[k];
            if ((STAGGER_EFF == 0) || (k == 0) || (r_move_ticks >= 32'(k * STAGGER_EFF))) begin
                if (r_pos[k] < r_target[k]) begin
                    if ((r_target[k] - r_pos[k]) > r_step)
                        w_pos_nxt[k] = r_pos[k] + r_step;
                    else
                        w_pos_nxt[k] = r_target[k];
                end else begin
                    if ((r_pos[k] - r_target[k]) > r_step)
                        w_pos_nxt[k] = r_pos[k] - r_step;
                    else
                        w_pos_nxt[k] = r_target[k];
                end
            end
            if (w_pos_nxt[k] != r_target[k])
                w_all_at = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.gesture_valid) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_MOVE;
            S_MOVE:   if (w_tick && w_all_at) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (w_hold_end)
                    w_state_nxt = (r_pending || bus.gesture_valid) ? S_LOAD : S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = w_hold_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_move_ticks <= '0;
            r_active     <= '0;
            r_pend_g     <= '0;
            r_pending    <= 1'b0;
            r_step       <= '0;
            for (int k = 0; k < 5; k++) begin
                r_pos[k]    <= PW_W'(OPEN_US);
                r_target[k] <= PW_W'(OPEN_US);
            end
        end else begin
            if (r_state == S_LOAD || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;

            if (r_state != S_SETTLE)
                r_hold_cnt <= '0;
            else if (w_tick && !w_hold_end)
                r_hold_cnt <= r_hold_cnt + 1'b1;

            if (r_state == S_LOAD)
                r_move_ticks <= '0;
            else if (r_state == S_MOVE && w_tick && r_move_ticks != '1)
                r_move_ticks <= r_move_ticks + 1'b1;

            if (r_state == S_LOAD) begin
                r_step <= w_step;
                for (int k = 0; k < 5; k++)
                    r_target[k] <= r_active[k] ? PW_W'(CLOSE_US) : PW_W'(OPEN_US);
            end

            if (r_state == S_MOVE && w_tick) begin
                for (int k = 0; k < 5; k++)
                    r_pos[k] <= w_pos_nxt[k];
            end

            // A request arriving with done goes straight to active only when nothing is queued.
            if (r_state == S_IDLE) begin
                if (bus.gesture_valid)
                    r_active <= bus.gesture;
            end else if (w_done) begin
                if (r_pending) begin
                    r_active  <= r_pend_g;
                    r_pending <= bus.gesture_valid;
                    if (bus.gesture_valid)
                        r_pend_g <= bus.gesture;
                end else if (bus.gesture_valid) begin
                    r_active <= bus.gesture;
                end
            end else if (bus.gesture_valid) begin
                r_pending <= 1'b1;
                r_pend_g  <= bus.gesture;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_pos
            assign bus.pos[g*PW_W +: PW_W] = r_pos[g];
        end
    endgenerate

    assign bus.busy    = w_busy;
    assign bus.pending = r_pending;
    assign bus.done    = w_done;

endmodule

// File: tb/tb_gesture_sequencer.sv
// Self-checking bench for gesture_sequencer: closed-form timing/position model,
// per-cycle compare, directed cases from the test plan and random gesture traffic.
module tb_gesture_sequencer;

    localparam int TD   = 4;
    localparam int STEP = 100;
    localparam int HOLD = 2;
`ifdef SEQ_STAGGER_EN
    localparam int ST   = 1;
`else
    localparam int ST   = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gesture_if #(.PW_W(16)) bus ();

    gesture_sequencer #(
        .PW_W(16), .OPEN_US(1000), .CLOSE_US(2000), .TICK_DIV(TD),
        .STEP_US(STEP), .HOLD_TICKS(HOLD), .STAGGER_TICKS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint cyc = 0;
    bit     m_ok = 0;
    bit     m_busy, m_pend;
    logic [7:0] m_pg;
    int     m_start [5];
    int     m_tgt   [5];
    int     m_step;
    longint m_m, m_d, m_T;
    int     e_pos [5];
    bit     e_busy, e_done, e_pend;

    function automatic int chpos(int s, int t, int st, longint j);
        longint p;
        if (s < t) begin
            p = s + j * st;
            if (p > t) p = t;
        end else begin
            p = s - j * st;
            if (p < t) p = t;
        end
        return int'(p);
    endfunction

    function automatic longint need(int s, int t, int st);
        int d;
        d = (s < t) ? t - s : s - t;
        return (d + st - 1) / st;
    endfunction

    task automatic accept(input logic [7:0] g, input longint a);
        longint n, tk;
        m_step = (STEP * (int'(g[7:5]) + 1)) & 16'hFFFF;
        m_T = 0;
        for (int k = 0; k < 5; k++) begin
            m_start[k] = m_tgt[k];
            m_tgt[k]   = g[k] ? 2000 : 1000;
            n = need(m_start[k], m_tgt[k], m_step);
            if (n > 0) begin
                tk = k * ST + n;
                if (tk > m_T) m_T = tk;
            end
        end
        if (m_T == 0) m_T = 1;
        m_m = a + 2;
        m_d = m_m + m_T * TD + HOLD * TD;
        m_busy = 1;
    endtask

    task automatic model_eval(input longint c);
        longint j, e;
        e_busy = m_busy;
        e_pend = m_pend;
        e_done = m_busy && (c == m_d);
        for (int k = 0; k < 5; k++) begin
            if (m_busy && c >= m_m) begin
                j = (c - m_m) / TD;
                if (j > m_T) j = m_T;
                e = j - k * ST;
                if (e < 0) e = 0;
                e_pos[k] = chpos(m_start[k], m_tgt[k], m_step, e);
            end else if (m_busy) begin
                e_pos[k] = m_start[k];
            end else begin
                e_pos[k] = m_tgt[k];
            end
        end
    endtask

    task automatic model_step();
        logic       v;
        logic [7:0] g;
        v = bus.gesture_valid;
        g = bus.gesture;
        if (rst) begin
            m_busy = 0;
            m_pend = 0;
            m_pg   = '0;
            for (int k = 0; k < 5; k++) begin
                m_start[k] = 1000;
                m_tgt[k]   = 1000;
            end
        end else if (!m_busy) begin
            if (v) accept(g, cyc);
        end else if (cyc == m_d) begin
            if (m_pend) begin
                accept(m_pg, cyc);
                m_pend = v;
                if (v) m_pg = g;
            end else if (v) begin
                accept(g, cyc);
            end else begin
                m_busy = 0;
            end
        end else if (v) begin
            m_pend = 1;
            m_pg   = g;
        end
        cyc++;
        model_eval(cyc);
        m_ok = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            for (int k = 0; k < 5; k++)
                check($sformatf("pos%0d", k), longint'(bus.pos[k*16 +: 16]), e_pos[k]);
            check("busy", bus.busy, e_busy);
            check("pending", bus.pending, e_pend);
            check("done", bus.done, e_done);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] g, output longint n);
        @(posedge clk);
        #1;
        bus.gesture       = g;
        bus.gesture_valid = 1'b1;
        n = cyc;
        @(posedge clk);
        #1;
        bus.gesture_valid = 1'b0;
    endtask

    task automatic at_cycle(input longint t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_done(input int max, output longint dc);
        bit seen;
        seen = 0;
        dc = -1;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                dc = cyc;
            end
        end
        if (!seen) check("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max);
        bit idle;
        idle = 0;
        for (int i = 0; i < max && !idle; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.pending) idle = 1;
        end
        if (!idle) check("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        longint n, n2, dc;
        bus.gesture       = '0;
        bus.gesture_valid = 1'b0;

        // reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++)
            check($sformatf("rst_pos%0d", k), longint'(bus.pos[k*16 +: 16]), 1000);
        check("rst_busy", bus.busy, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_done", bus.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // full close at slowest speed
        send(8'h1F, n);
        at_cycle(n + 1);
        check("t1_busy_load", bus.busy, 1);
        at_cycle(n + 5);
        check("t1_pos0_pre_tick", longint'(bus.pos[15:0]), 1000);
        at_cycle(n + 6);
        check("t1_pos0_tick1", longint'(bus.pos[15:0]), 1100);
        check("t1_pos1_tick1", longint'(bus.pos[31:16]), (ST == 0) ? 1100 : 1000);
        wait_done(400, dc);
        check("t1_done_latency", dc - n, (ST == 0) ? 50 : 66);
        at_cycle(dc + 1);
        check("t1_busy_after_done", bus.busy, 0);
        for (int k = 0; k < 5; k++)
            check($sformatf("t1_final%0d", k), longint'(bus.pos[k*16 +: 16]), 2000);

        // fast speed with clamp, from all-open
        do_reset(2);
        send(8'hE5, n);
        at_cycle(n + 6);
        check("t2_pos0_tick1", longint'(bus.pos[15:0]), 1800);
        check("t2_pos1_tick1", longint'(bus.pos[31:16]), 1000);
        wait_idle(400);
        check("t2_pos0", longint'(bus.pos[15:0]), 2000);
        check("t2_pos2", longint'(bus.pos[47:32]), 2000);
        check("t2_pos3", longint'(bus.pos[63:48]), 1000);

        // pending overwrite: latest wins
        do_reset(1);
        send(8'h1F, n);
        at_cycle(n + 10);
        send(8'h03, n2);
        send(8'h18, n2);
        @(negedge clk);
        check("t3_pending", bus.pending, 1);
        wait_idle(800);
        check("t3_pos0", longint'(bus.pos[15:0]), 1000);
        check("t3_pos1", longint'(bus.pos[31:16]), 1000);
        check("t3_pos3", longint'(bus.pos[63:48]), 2000);
        check("t3_pos4", longint'(bus.pos[79:64]), 2000);

        // reset mid-move with a pending gesture
        send(8'h07, n);
        at_cycle(n + 8);
        send(8'h10, n2);
        do_reset(1);
        @(negedge clk);
        check("t4_pos2", longint'(bus.pos[47:32]), 1000);
        check("t4_pos3", longint'(bus.pos[63:48]), 1000);
        check("t4_busy", bus.busy, 0);
        check("t4_pending", bus.pending, 0);

        // gesture equal to current positions: one tick, full settle
        send(8'h00, n);
        wait_done(100, dc);
        check("t5_done_latency", dc - n, 2 + TD + HOLD * TD);

        // random traffic
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            if ($urandom_range(0, 24) == 0)
                do_reset($urandom_range(1, 3));
            send(8'($urandom), n);
        end
        wait_idle(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gesture_sequencer.md
# gesture_sequencer

Motion controller between the gesture input stage and the five servo PWM generators of the bionic arm. Accepts one 8-bit gesture code per request and converts it to five per-finger pulse-width targets. Slews every channel toward its target at a gesture-selected rate, then holds for a settle period. Buffers one pending gesture so back-to-back requests are never lost mid-motion.

## Interface
- PW_W, 16: width of one pulse-width value, units of µs
- OPEN_US, 1000: pulse width for finger open (gesture bit = 0)
- CLOSE_US, 2000: pulse width for finger closed (gesture bit = 1)
- TICK_DIV, 50000: clk cycles per motion tick (1 ms at 50 MHz)
- STEP_US, 10: base slew per tick in µs
- HOLD_TICKS, 20: settle ticks after all channels reach target
- STAGGER_TICKS, 5: per-channel start offset, used only with SEQ_STAGGER_EN

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- gesture  in  8  [4:0] finger close mask (bit k → channel k); [7:5] speed code S
- gesture_valid  in  1  single-cycle request strobe, qualifies gesture
- pos  out  5*PW_W  packed current pulse widths; channel k at [k*PW_W +: PW_W]
- busy  out  1  high in any state other than IDLE
- pending  out  1  pending buffer holds a gesture
- done  out  1  one-cycle pulse when a gesture's settle period ends

## Operation
- States: IDLE, LOAD, MOVE, SETTLE.
- IDLE: gesture_valid → latch gesture into active register, go LOAD.
- LOAD (1 cycle): target[k] = gesture[k] ? CLOSE_US : OPEN_US; step = STEP_US*(S+1), computed at PW_W bits; clear tick counter; go MOVE.
- MOVE: on each tick (tick counter reaching TICK_DIV-1, then wrapping to 0), every enabled channel with pos≠target moves toward target by min(step, |target−pos|); never overshoots, no wrap. When all five pos==target at a tick evaluation, go SETTLE and clear tick/hold counters.
- SETTLE: count HOLD_TICKS ticks; on the last, pulse done. If pending set, go LOAD using the pending gesture and clear pending in that cycle; else go IDLE.
- gesture_valid while busy: write into the pending buffer and set pending; if already full, overwrite (latest wins). gesture_valid in the same cycle as done-with-pending: new gesture goes into the now-freed pending buffer.
- Gesture identical to current positions: MOVE exits at first tick, full settle still applied.
- Reset mid-operation: all state discarded, outputs to reset values the next cycle.

## Timing
- Reset values: pos all channels = OPEN_US; busy=0; pending=0; done=0; state IDLE.
- gesture_valid at cycle n in IDLE: busy=1 at n+1 (LOAD); MOVE entered n+2; first pos change at n+2+TICK_DIV.
- pos changes only on tick cycles, registered.
- done rises exactly HOLD_TICKS*TICK_DIV cycles after SETTLE entry; busy falls the cycle after done when no pending gesture.
- Total motion ticks per channel = ceil(|target−start|/step).

## Configuration
- SEQ_STAGGER_EN defined: channel k may move only after k*STAGGER_TICKS ticks have elapsed in MOVE; completion check still requires all channels at target. Gives a wave-like finger motion.
- Undefined: all channels start moving on the first tick; STAGGER_TICKS ignored.

## Test plan
Benches use TICK_DIV=4, STEP_US=100, HOLD_TICKS=2.
- Reset: assert rst 3 cycles → pos all 1000, busy=0, pending=0, done=0.
- gesture 0x1F (S=0) → each channel steps 1000→2000 over 10 ticks in 100 µs increments; done at 10 ticks + 8 cycles after MOVE entry; busy low the next cycle.
- gesture 0xE5 (S=7, step 800) from all-open → channels 0,2 go 1000→1800→2000 (clamped, no overshoot) in 2 ticks; channels 1,3,4 stay 1000.
- During motion send 0x03 then 0x18 → pending=1, 0x18 executed after first done, 0x03 never applied; final pos channels 3,4=2000, others 1000.
- Assert rst mid-MOVE → next cycle pos all 1000, busy=0, pending=0.
- With SEQ_STAGGER_EN, STAGGER_TICKS=1, gesture 0x1F → channel k first moves at tick k+1; completion after tick 14.
